logic_gate_lab: RTL and testbench

Parametrised, mode-selectable successor to the two-input gate demonstrators for the BASYS 3 board. NUM_IN slide switches are synchronised and debounced, then reduced by one of six gate functions (AND, OR, XOR, NAND, NOR, XNOR). A debounced pushbutton selects the active function. LEDs mirror the debounced inputs, the gate result and the active mode (one-hot).

---
 rtl/logic_gate_lab.sv | 156 +++++++++++++++
 tb/tb_logic_gate_lab.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_gate_lab.sv
// rtl/logic_gate_lab.sv - debounced multi-input gate demonstrator with button-selected gate function
module logic_gate_lab #(
    parameter int NUM_IN          = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int RESET_MODE      = 5
) (
    input  logic              I_P_CLK,
    input  logic              I_P_RST_N,
    input  logic [NUM_IN-1:0] I_P_SW,
    input  logic              I_P_BTN_MODE,
    output logic [NUM_IN-1:0] O_P_LED_IN,
    output logic              O_P_LED_GATE,
    output logic [5:0]        O_P_LED_MODE
);

    typedef enum logic [2:0] {
        MODE_AND  = 3'd0,
        MODE_OR   = 3'd1,
        MODE_XOR  = 3'd2,
        MODE_NAND = 3'd3,
        MODE_NOR  = 3'd4,
        MODE_XNOR = 3'd5
    } mode_t;

    // Switches occupy the low bits, the mode button the top bit.
    localparam int NSIG = NUM_IN + 1;
    localparam int CW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam mode_t MODE_RST = mode_t'(3'(RESET_MODE));

    if (NUM_IN < 2 || NUM_IN > 8) begin : g_bad_num_in
        $fatal(1, "logic_gate_lab: NUM_IN must be in 2..8");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $fatal(1, "logic_gate_lab: DEBOUNCE_CYCLES must be at least 2");
    end
    if (RESET_MODE < 0 || RESET_MODE > 5) begin : g_bad_reset_mode
        $fatal(1, "logic_gate_lab: RESET_MODE must be in 0..5");
    end

    logic [NSIG-1:0]   raw;
    logic [NSIG-1:0]   sync1;
    logic [NSIG-1:0]   sync2;
    logic [NSIG-1:0]   stable;
    logic [NUM_IN-1:0] sw_stable;
    logic              btn_stable;
    logic              btn_prev;
    logic              btn_rise;
    logic [1:0]        sync_fill;
    logic              btn_armed;
    mode_t             mode;
    mode_t             mode_next;
    logic              gate_next;
    logic              gate_q;

    assign raw        = {I_P_BTN_MODE, I_P_SW};
    assign sw_stable  = stable[NUM_IN-1:0];
    assign btn_stable = stable[NUM_IN];

    // Two-flop synchroniser for every switch and the button.
    always_ff @(posedge I_P_CLK or negedge I_P_RST_N) begin
        if (!I_P_RST_N) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < NSIG; i++) begin : g_deb
        logic [CW-1:0] cnt;
        logic          lvl;

        // Accept a new level only after it has differed for DEBOUNCE_CYCLES consecutive cycles.
        always_ff @(posedge I_P_CLK or negedge I_P_RST_N) begin
            if (!I_P_RST_N) begin
                cnt <= '0;
                lvl <= 1'b0;
            end else if (sync2[i] == lvl) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                lvl <= sync2[i];
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end

        assign stable[i] = lvl;
    end

    // A button held through reset must be seen released (after the synchroniser
    // has refilled) before a press may advance the mode.
    assign btn_rise = btn_stable & ~btn_prev & btn_armed;

    // Edge-detect register and press arming.
    always_ff @(posedge I_P_CLK or negedge I_P_RST_N) begin
        if (!I_P_RST_N) begin
            btn_prev  <= 1'b0;
            sync_fill <= 2'b00;
            btn_armed <= 1'b0;
        end else begin
            btn_prev  <= btn_stable;
            sync_fill <= {sync_fill[0], 1'b1};
            btn_armed <= btn_armed | (sync_fill[1] & ~sync2[NUM_IN]);
        end
    end

    // Mode state register.
    always_ff @(posedge I_P_CLK or negedge I_P_RST_N) begin
        if (!I_P_RST_N) begin
            mode <= MODE_RST;
        end else begin
            mode <= mode_next;
        end
    end

    // Mode advance on a debounced press; illegal codes recover to AND.
    always_comb begin
        mode_next = mode;
        if (mode > MODE_XNOR) begin
            mode_next = MODE_AND;
        end else if (btn_rise) begin
            mode_next = (mode == MODE_XNOR) ? MODE_AND : mode_t'(mode + 3'd1);
        end
    end

    // Gate function over all debounced switches for the current mode.
    always_comb begin
        gate_next = 1'b0;
        case (mode)
            MODE_AND:  gate_next = &sw_stable;
            MODE_OR:   gate_next = |sw_stable;
            MODE_XOR:  gate_next = ^sw_stable;
            MODE_NAND: gate_next = ~&sw_stable;
            MODE_NOR:  gate_next = ~|sw_stable;
            MODE_XNOR: gate_next = ~^sw_stable;
            default:   gate_next = 1'b0;
        endcase
    end

    // Registered gate result.
    always_ff @(posedge I_P_CLK or negedge I_P_RST_N) begin
        if (!I_P_RST_N) begin
            gate_q <= 1'b0;
        end else begin
            gate_q <= gate_next;
        end
    end

    assign O_P_LED_IN   = sw_stable;
    assign O_P_LED_GATE = gate_q;
    assign O_P_LED_MODE = (mode > MODE_XNOR) ? 6'd0 : (6'd1 << mode);

endmodule

// File: tb/tb_logic_gate_lab.sv
// tb/tb_logic_gate_lab.sv - randomized and directed checks of logic_gate_lab against a behavioural model
module tb_logic_gate_lab;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       btn = 1'b0;
    logic [1:0] sw2 = '0;
    logic [7:0] sw8 = '0;
    logic [1:0] led_in2;
    logic [7:0] led_in8;
    logic       gate2;
    logic       gate8;
    logic [5:0] led_mode2;
    logic [5:0] led_mode8;

    int checks = 0;
    int passed = 0;

    logic [10:0] m_rq[$];
    logic [10:0] m_sq[$];
    logic [10:0] m_stable;
    logic        m_prev;
    logic        m_armed;
    logic        m_gate2;
    logic        m_gate8;
    int          m_mode;
    int          m_edges;

    logic [23:0] obs;
    assign obs = {led_in8, gate8, led_in2, gate2, led_mode8, led_mode2};

    always #5 clk = ~clk;

    logic_gate_lab #(.NUM_IN(2), .DEBOUNCE_CYCLES(DEB), .RESET_MODE(5)) dut2 (
        .I_P_CLK(clk), .I_P_RST_N(rst_n), .I_P_SW(sw2), .I_P_BTN_MODE(btn),
        .O_P_LED_IN(led_in2), .O_P_LED_GATE(gate2), .O_P_LED_MODE(led_mode2)
    );

    logic_gate_lab #(.NUM_IN(8), .DEBOUNCE_CYCLES(DEB), .RESET_MODE(5)) dut8 (
        .I_P_CLK(clk), .I_P_RST_N(rst_n), .I_P_SW(sw8), .I_P_BTN_MODE(btn),
        .O_P_LED_IN(led_in8), .O_P_LED_GATE(gate8), .O_P_LED_MODE(led_mode8)
    );

    function automatic logic gate_ref(int mode, logic [7:0] v, int n);
        int ones = 0;
        for (int i = 0; i < n; i++) ones += int'(v[i]);
        case (mode)
            0: return ones == n;
            1: return ones > 0;
            2: return (ones % 2) == 1;
            3: return ones != n;
            4: return ones == 0;
            5: return (ones % 2) == 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [23:0] exp_vec();
        logic [5:0] oh;
        oh = (m_mode < 6) ? (6'd1 << m_mode) : 6'd0;
        return {m_stable[9:2], m_gate8, m_stable[1:0], m_gate2, oh, oh};
    endfunction

    task automatic model_reset();
        m_rq = {};
        m_sq = {};
        for (int i = 0; i < 2; i++) m_rq.push_back('0);
        for (int i = 0; i < DEB; i++) m_sq.push_back('0);
        m_stable = '0;
        m_prev   = 1'b0;
        m_armed  = 1'b0;
        m_gate2  = 1'b0;
        m_gate8  = 1'b0;
        m_mode   = 5;
        m_edges  = 0;
    endtask

    // One clock edge of the reference: levels seen two edges late; a level is
    // accepted once the last DEB seen samples all disagree with the accepted level.
    task automatic model_edge();
        logic [10:0] seen;
        logic        rise;
        logic        g2;
        logic        g8;
        logic        diff;
        g2 = gate_ref(m_mode, {6'b0, m_stable[1:0]}, 2);
        g8 = gate_ref(m_mode, m_stable[9:2], 8);
        rise = m_stable[10] && !m_prev && m_armed;
        m_prev = m_stable[10];
        if (rise) m_mode = (m_mode + 1) % 6;
        m_edges++;
        m_rq.push_back({btn, sw8, sw2});
        seen = m_rq.pop_front();
        if (m_edges >= 3 && !seen[10]) m_armed = 1'b1;
        m_sq.push_back(seen);
        void'(m_sq.pop_front());
        for (int b = 0; b < 11; b++) begin
            diff = 1'b1;
            foreach (m_sq[j]) if (m_sq[j][b] == m_stable[b]) diff = 1'b0;
            if (diff) m_stable[b] = ~m_stable[b];
        end
        m_gate2 = g2;
        m_gate8 = g8;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
    endtask

    task automatic cycles(int n);
        repeat (n) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sw2 = '0;
        sw8 = '0;
        btn = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        checks++; if (led_in2 !== 2'b00) $display("FAIL reset_led_in got=%b exp=00", led_in2); else passed++;
        checks++; if (gate2 !== 1'b0) $display("FAIL reset_gate got=%b exp=0", gate2); else passed++;
        checks++; if (led_mode2 !== 6'b100000) $display("FAIL reset_mode got=%b exp=100000", led_mode2); else passed++;
        checks++; if (obs !== exp_vec()) $display("FAIL reset_model got=%h exp=%h", obs, exp_vec()); else passed++;
        rst_n = 1'b1;
        tick();
        checks++; if (gate2 !== 1'b1) $display("FAIL reset_first_gate got=%b exp=1", gate2); else passed++;
        checks++; if (obs !== exp_vec()) $display("FAIL reset_release_model got=%h exp=%h", obs, exp_vec()); else passed++;
    endtask

    task automatic test_switch_latency();
        sw2 = 2'b01;
        for (int i = 1; i <= 8; i++) begin
            tick();
            checks++;
            if (led_in2 !== ((i >= 6) ? 2'b01 : 2'b00))
                $display("FAIL latency_led_in t+%0d got=%b", i, led_in2);
            else passed++;
            checks++;
            if (gate2 !== ((i >= 7) ? 1'b0 : 1'b1))
                $display("FAIL latency_gate t+%0d got=%b", i, gate2);
            else passed++;
        end
        sw2 = 2'b11;
        cycles(8);
        checks++; if (gate2 !== 1'b1) $display("FAIL latency_gate_11 got=%b exp=1", gate2); else passed++;
        checks++; if (obs !== exp_vec()) $display("FAIL latency_model got=%h exp=%h", obs, exp_vec()); else passed++;
    endtask

    task automatic test_bounce();
        sw2 = 2'b00;
        cycles(8);
        sw2 = 2'b01; cycles(2);
        sw2 = 2'b00; cycles(2);
        sw2 = 2'b01;
        for (int j = 1; j <= 8; j++) begin
            tick();
            checks++;
            if (led_in2[0] !== (j >= 6))
                $display("FAIL bounce_led_in hold+%0d got=%b exp=%b", j, led_in2[0], (j >= 6));
            else passed++;
            checks++;
            if (obs !== exp_vec()) $display("FAIL bounce_model got=%h exp=%h", obs, exp_vec()); else passed++;
        end
    endtask

    task automatic test_modes();
        logic [5:0] gate_tbl;
        logic [5:0] last_mode;
        int         changes;
        gate_tbl = 6'b100011;
        sw2 = 2'b11;
        sw8 = 8'($urandom);
        cycles(8);
        for (int p = 0; p < 6; p++) begin
            btn = 1'b1; cycles(10);
            btn = 1'b0; cycles(10);
            checks++;
            if (led_mode2 !== (6'd1 << p)) $display("FAIL press_mode p=%0d got=%b", p, led_mode2); else passed++;
            checks++;
            if (gate2 !== gate_tbl[p]) $display("FAIL press_gate p=%0d got=%b exp=%b", p, gate2, gate_tbl[p]); else passed++;
            checks++;
            if (obs !== exp_vec()) $display("FAIL press_model p=%0d got=%h exp=%h", p, obs, exp_vec()); else passed++;
        end
        changes = 0;
        last_mode = led_mode2;
        btn = 1'b1;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (led_mode2 !== last_mode) changes++;
            last_mode = led_mode2;
            checks++;
            if (obs !== exp_vec()) $display("FAIL hold_model k=%0d got=%h exp=%h", k, obs, exp_vec()); else passed++;
        end
        btn = 1'b0;
        cycles(10);
        checks++; if (changes !== 1) $display("FAIL hold_advances got=%0d exp=1", changes); else passed++;
        checks++; if (led_mode2 !== 6'b000001) $display("FAIL hold_wrap got=%b exp=000001", led_mode2); else passed++;
    endtask

    task automatic test_num_in8();
        repeat (2) begin
            btn = 1'b1; cycles(10);
            btn = 1'b0; cycles(10);
        end
        sw8 = 8'b1011_0001;
        cycles(8);
        checks++; if (led_in8 !== 8'b1011_0001) $display("FAIL n8_led_in got=%b", led_in8); else passed++;
        checks++; if (gate8 !== 1'b0) $display("FAIL n8_xor_even got=%b exp=0", gate8); else passed++;
        sw8[1] = 1'b1;
        cycles(8);
        checks++; if (gate8 !== 1'b1) $display("FAIL n8_xor_odd got=%b exp=1", gate8); else passed++;
        repeat (2) begin
            btn = 1'b1; cycles(10);
            btn = 1'b0; cycles(10);
        end
        sw8 = 8'h00;
        cycles(8);
        checks++; if (led_mode8 !== 6'b010000) $display("FAIL n8_mode got=%b exp=010000", led_mode8); else passed++;
        checks++; if (gate8 !== 1'b1) $display("FAIL n8_nor_zero got=%b exp=1", gate8); else passed++;
        checks++; if (obs !== exp_vec()) $display("FAIL n8_model got=%h exp=%h", obs, exp_vec()); else passed++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(3) == 0) sw2 = 2'($urandom);
            if ($urandom_range(2) == 0) sw8[$urandom_range(7)] ^= 1'b1;
            if ($urandom_range(9) == 0) btn = ~btn;
            tick();
            checks++;
            if (obs !== exp_vec()) $display("FAIL random_model c=%0d got=%h exp=%h", c, obs, exp_vec()); else passed++;
        end
        btn = 1'b0;
        cycles(10);
    endtask

    task automatic test_reset_mid();
        sw2 = 2'b00;
        cycles(10);
        sw2 = 2'b01;
        btn = 1'b1;
        cycles(4);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (led_in2 !== 2'b00) $display("FAIL mid_reset_led_in got=%b exp=00", led_in2); else passed++;
        checks++; if (gate2 !== 1'b0) $display("FAIL mid_reset_gate got=%b exp=0", gate2); else passed++;
        checks++; if (led_mode2 !== 6'b100000) $display("FAIL mid_reset_mode got=%b exp=100000", led_mode2); else passed++;
        checks++; if (obs !== exp_vec()) $display("FAIL mid_reset_model got=%h exp=%h", obs, exp_vec()); else passed++;
        cycles(3);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) $display("FAIL held_model k=%0d got=%h exp=%h", k, obs, exp_vec()); else passed++;
        end
        checks++; if (led_mode2 !== 6'b100000) $display("FAIL held_no_advance got=%b exp=100000", led_mode2); else passed++;
        btn = 1'b0; cycles(10);
        checks++; if (led_mode2 !== 6'b100000) $display("FAIL release_no_advance got=%b exp=100000", led_mode2); else passed++;
        btn = 1'b1; cycles(10);
        checks++; if (led_mode2 !== 6'b000001) $display("FAIL repress_advance got=%b exp=000001", led_mode2); else passed++;
        checks++; if (obs !== exp_vec()) $display("FAIL repress_model got=%h exp=%h", obs, exp_vec()); else passed++;
        btn = 1'b0; cycles(10);
    endtask

    initial begin
        test_reset();
        test_switch_latency();
        test_bounce();
        test_modes();
        test_num_in8();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
